// File: rtl/uart_cmd_responder.sv
// UART command responder: parses 5-byte 0x55 frames, issues one register read/write,
// and returns a 4-byte 0xAA response through the UART transmitter handshake.
module uart_cmd_responder #(
    parameter int REG_COUNT   = 16,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    output logic [7:0] tx_data,
    output logic       tx_int,
    input  logic       tx_busy,
    output logic       reg_we,
    output logic       reg_re,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       frame_err
);

    localparam int       TW       = 26;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] SYNC_B = 8'h55;
    localparam logic [7:0] RESP_B = 8'hAA;
    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_CHK = 8'hE1;
    localparam logic [7:0] ST_CMD = 8'hE2;
    localparam logic [7:0] ST_ADR = 8'hE3;

    typedef enum logic [3:0] {
        S_HUNT, S_CMD, S_ADDR, S_DATA, S_CHK,
        S_EXEC, S_RDWAIT, S_TX_LOAD, S_TX_WAITHI, S_TX_WAITLO
    } state_t;

    state_t          state_q, state_d;
    logic            rdy_q;
    logic [7:0]      cmd_q, addr_q, data_q;
    logic [7:0]      status_q, status_d;
    logic [7:0]      val_q;
    logic            is_wr_q;
    logic [1:0]      idx_q, idx_nxt;
    logic [TW-1:0]   tmo_q;
    logic [7:0]      tx_data_q, reg_addr_q, reg_wdata_q;
    logic [7:0]      resp_byte;

    logic byte_stb, in_frame, tmo_hit, chk_ok, cmd_ok, addr_ok;
    logic [7:0] sum;

    assign byte_stb = rx_data_ready & ~rdy_q;
    assign in_frame = (state_q == S_CMD) || (state_q == S_ADDR) ||
                      (state_q == S_DATA) || (state_q == S_CHK);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit  = in_frame && !byte_stb && (tmo_q == TMO_LAST);

    // Frame checks, meaningful while the CHK byte is on rx_data.
    assign sum     = cmd_q + addr_q + data_q;
    assign chk_ok  = (sum == rx_data);
    assign cmd_ok  = (cmd_q == 8'h01) || (cmd_q == 8'h02);
    assign addr_ok = ({1'b0, addr_q} < 9'(REG_COUNT));

    always_comb begin
        status_d = ST_OK;
        if (!chk_ok)       status_d = ST_CHK;
        else if (!cmd_ok)  status_d = ST_CMD;
        else if (!addr_ok) status_d = ST_ADR;
    end

    assign idx_nxt = (state_q == S_TX_WAITLO) ? idx_q + 2'd1 : idx_q;

    always_comb begin
        case (idx_nxt)
            2'd0:    resp_byte = RESP_B;
            2'd1:    resp_byte = status_q;
            2'd2:    resp_byte = val_q;
            default: resp_byte = status_q + val_q;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_HUNT;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HUNT:      if (byte_stb && rx_data == SYNC_B) state_d = S_CMD;
            S_CMD:       if (tmo_hit) state_d = S_HUNT; else if (byte_stb) state_d = S_ADDR;
            S_ADDR:      if (tmo_hit) state_d = S_HUNT; else if (byte_stb) state_d = S_DATA;
            S_DATA:      if (tmo_hit) state_d = S_HUNT; else if (byte_stb) state_d = S_CHK;
            S_CHK:       if (tmo_hit) state_d = S_HUNT; else if (byte_stb) state_d = S_EXEC;
            S_EXEC:      state_d = (status_q != ST_OK || is_wr_q) ? S_TX_LOAD : S_RDWAIT;
            S_RDWAIT:    state_d = S_TX_LOAD;
            S_TX_LOAD:   state_d = S_TX_WAITHI;
            S_TX_WAITHI: if (tx_busy) state_d = S_TX_WAITLO;
            S_TX_WAITLO: if (!tx_busy) state_d = (idx_q == 2'd3) ? S_HUNT : S_TX_LOAD;
            default:     state_d = S_HUNT;
        endcase
    end

    // Output logic
    always_comb begin
        tx_int    = 1'b0;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        frame_err = tmo_hit;
        case (state_q)
            S_EXEC: begin
                if (status_q != ST_OK) frame_err = 1'b1;
                else if (is_wr_q)      reg_we    = 1'b1;
                else                   reg_re    = 1'b1;
            end
            S_TX_LOAD: tx_int = 1'b1;
            default: ;
        endcase
    end

    assign tx_data   = tx_data_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;

    // Datapath: edge detect, frame capture, timeout, response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q       <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            status_q    <= '0;
            val_q       <= '0;
            is_wr_q     <= 1'b0;
            idx_q       <= '0;
            tmo_q       <= '0;
            tx_data_q   <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            rdy_q <= rx_data_ready;
            tmo_q <= (in_frame && !byte_stb) ? tmo_q + TW'(1) : '0;

            if (byte_stb) begin
                case (state_q)
                    S_CMD:   cmd_q  <= rx_data;
                    S_ADDR:  addr_q <= rx_data;
                    S_DATA:  data_q <= rx_data;
                    default: ;
                endcase
            end

            if (state_q == S_CHK && byte_stb) begin
                status_q <= status_d;
                is_wr_q  <= (cmd_q == 8'h01);
                val_q    <= (status_d == ST_OK && cmd_q == 8'h01) ? data_q : 8'h00;
                // Bus address/data only move when a strobe will follow.
                if (status_d == ST_OK) begin
                    reg_addr_q <= addr_q;
                    if (cmd_q == 8'h01) reg_wdata_q <= data_q;
                end
            end

            if (state_q == S_RDWAIT) val_q <= reg_rdata;

            if (state_d == S_TX_LOAD) tx_data_q <= resp_byte;

            if (state_q == S_TX_WAITLO && !tx_busy) idx_q <= idx_q + 2'd1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with a behavioural transmitter and register-read model.
module tb_uart_cmd_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_int;
    logic       tx_busy = 1'b0;
    logic       reg_we, reg_re;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] reg_rdata = 8'hFF;
    logic       frame_err;

    uart_cmd_responder #(.REG_COUNT(16), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
        .tx_data(tx_data), .tx_int(tx_int), .tx_busy(tx_busy),
        .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, ntx = 0, nwe = 0, nre = 0, nerr = 0, stab_err = 0, pace_err = 0;
    int we_cyc = 0, re_cyc = 0, busy_len = 3, busy_cnt = 0, rd_phase = 0;
    int tx_cyc[$];
    logic [7:0] txq[$];
    logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00, last_tx = 8'h00;
    logic [7:0] rd_val = 8'h3C;
    bit chk_stab = 1'b0;

    // Transmitter model, bus monitors and read-data driver, all on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) chk_stab = 1'b0;
        else if (chk_stab && tx_busy && tx_data !== last_tx) stab_err++;
        if (tx_int) begin
            if (tx_busy) pace_err++;
            txq.push_back(tx_data);
            tx_cyc.push_back(cyc);
            last_tx  = tx_data;
            chk_stab = 1'b1;
            ntx++;
            tx_busy  = 1'b1;
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_busy  = 1'b0;
                chk_stab = 1'b0;
            end
        end
        if (reg_we) begin nwe++; we_addr = reg_addr; we_data = reg_wdata; we_cyc = cyc; end
        if (frame_err) nerr++;
        // Valid read data only in the cycle after reg_re.
        if (rd_phase == 1) begin reg_rdata = rd_val; rd_phase = 2; end
        else if (rd_phase == 2) begin reg_rdata = 8'hFF; rd_phase = 0; end
        if (reg_re) begin nre++; re_addr = reg_addr; re_cyc = cyc; rd_phase = 1; end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_data = b;
        rx_data_ready = 1'b1;
        tick(); tick();
        rx_data_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 4; i >= 0; i--) send_byte(f[8*i +: 8]);
    endtask

    task automatic wait_tx(input int target, input int budget, input string name);
        int left;
        left = budget;
        while (ntx < target && left > 0) begin tick(); left--; end
        checks++;
        if (ntx < target) begin
            errors++;
            $display("FAIL %s_tx_timeout: got %0d tx_int pulses, expected %0d", name, ntx, target);
        end
        repeat (busy_len + 10) tick();
    endtask

    function automatic logic [31:0] txword(input int b);
        if (txq.size() < b + 4) return 32'hxxxxxxxx;
        return {txq[b], txq[b+1], txq[b+2], txq[b+3]};
    endfunction

    task automatic test_reset();
        logic [34:0] outs;
        repeat (3) tick();
        outs = {tx_data, tx_int, reg_we, reg_re, reg_addr, reg_wdata, frame_err};
        checks++;
        if (outs !== 35'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_write();
        int b, w, r, e;
        b = ntx; w = nwe; r = nre; e = nerr;
        send_frame(40'h55_01_03_A5_A9);
        wait_tx(b + 4, 200, "write");
        checks++; if (txword(b) !== 32'hAA00A5A5) begin errors++; $display("FAIL write_resp: got %h expected AA00A5A5", txword(b)); end
        checks++; if (nwe - w != 1) begin errors++; $display("FAIL write_we_count: got %0d expected 1", nwe - w); end
        checks++; if (we_addr !== 8'h03) begin errors++; $display("FAIL write_addr: got %h expected 03", we_addr); end
        checks++; if (we_data !== 8'hA5) begin errors++; $display("FAIL write_data: got %h expected A5", we_data); end
        checks++; if (nre - r != 0 || nerr - e != 0) begin errors++; $display("FAIL write_extra: got re=%0d err=%0d expected 0 0", nre - r, nerr - e); end
        checks++; if (tx_cyc[b] - we_cyc != 1) begin errors++; $display("FAIL write_latency: got %0d expected 1", tx_cyc[b] - we_cyc); end
        checks++; if (ntx - b != 4) begin errors++; $display("FAIL write_tx_count: got %0d expected 4", ntx - b); end
    endtask

    task automatic test_read();
        int b, w, r;
        b = ntx; w = nwe; r = nre;
        send_frame(40'h55_02_05_00_07);
        wait_tx(b + 4, 200, "read");
        checks++; if (txword(b) !== 32'hAA003C3C) begin errors++; $display("FAIL read_resp: got %h expected AA003C3C", txword(b)); end
        checks++; if (nre - r != 1 || nwe - w != 0) begin errors++; $display("FAIL read_strobes: got re=%0d we=%0d expected 1 0", nre - r, nwe - w); end
        checks++; if (re_addr !== 8'h05) begin errors++; $display("FAIL read_addr: got %h expected 05", re_addr); end
        checks++; if (tx_cyc[b] - re_cyc != 2) begin errors++; $display("FAIL read_latency: got %0d expected 2", tx_cyc[b] - re_cyc); end
    endtask

    task automatic test_errors();
        logic [39:0] frm [3];
        logic [31:0] exp [3];
        int b, w, r, e;
        frm[0] = 40'h55_01_03_A5_00; exp[0] = 32'hAAE100E1;
        frm[1] = 40'h55_07_00_00_07; exp[1] = 32'hAAE200E2;
        frm[2] = 40'h55_01_10_00_11; exp[2] = 32'hAAE300E3;
        for (int i = 0; i < 3; i++) begin
            b = ntx; w = nwe; r = nre; e = nerr;
            send_frame(frm[i]);
            wait_tx(b + 4, 200, "err");
            checks++; if (txword(b) !== exp[i]) begin errors++; $display("FAIL err%0d_resp: got %h expected %h", i, txword(b), exp[i]); end
            checks++; if (nerr - e != 1) begin errors++; $display("FAIL err%0d_frame_err: got %0d expected 1", i, nerr - e); end
            checks++; if (nwe - w + nre - r != 0) begin errors++; $display("FAIL err%0d_strobe: got %0d expected 0", i, nwe - w + nre - r); end
        end
    endtask

    task automatic test_garbage();
        int b, e;
        b = ntx; e = nerr;
        send_byte(8'h12);
        send_byte(8'h34);
        send_frame(40'h55_01_07_11_19);
        wait_tx(b + 4, 200, "garbage");
        checks++; if (txword(b) !== 32'hAA001111) begin errors++; $display("FAIL garbage_resp: got %h expected AA001111", txword(b)); end
        checks++; if (nerr - e != 0) begin errors++; $display("FAIL garbage_frame_err: got %0d expected 0", nerr - e); end
        checks++; if (reg_addr !== 8'h07 || reg_wdata !== 8'h11) begin errors++; $display("FAIL bus_hold: got %h/%h expected 07/11", reg_addr, reg_wdata); end
    endtask

    task automatic test_timeout();
        int b, e, at;
        b = ntx; e = nerr; at = -1;
        send_byte(8'h55);
        send_byte(8'h01);
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (at < 0 && nerr != e) at = i;
        end
        checks++; if (nerr - e != 1) begin errors++; $display("FAIL timeout_frame_err: got %0d expected 1", nerr - e); end
        checks++; if (at != 96) begin errors++; $display("FAIL timeout_when: got %0d expected 96", at); end
        checks++; if (ntx != b) begin errors++; $display("FAIL timeout_tx: got %0d expected 0", ntx - b); end
    endtask

    task automatic test_back_to_back_busy();
        int b, w, left;
        busy_len = 1000;
        b = ntx; w = nwe;
        send_frame(40'h55_01_02_5A_5D);
        left = 300;
        while (ntx < b + 1 && left > 0) begin tick(); left--; end
        send_frame(40'h55_01_02_5A_5D);
        wait_tx(b + 4, 6000, "busy");
        checks++; if (ntx - b != 4) begin errors++; $display("FAIL busy_tx_count: got %0d expected 4", ntx - b); end
        checks++; if (txword(b) !== 32'hAA005A5A) begin errors++; $display("FAIL busy_resp: got %h expected AA005A5A", txword(b)); end
        checks++; if (nwe - w != 1) begin errors++; $display("FAIL busy_we_count: got %0d expected 1", nwe - w); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL tx_data_stable: got %0d changes expected 0", stab_err); end
        checks++; if (pace_err != 0) begin errors++; $display("FAIL tx_pacing: got %0d early pulses expected 0", pace_err); end
        busy_len = 3;
    endtask

    task automatic test_reset_mid();
        logic [34:0] outs;
        int b, left;
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h03);
        rst = 1'b1;
        tick();
        outs = {tx_data, tx_int, reg_we, reg_re, reg_addr, reg_wdata, frame_err};
        checks++; if (outs !== 35'h0) begin errors++; $display("FAIL rst_midframe: got %h expected 0", outs); end
        rst = 1'b0;
        b = ntx;
        send_frame(40'h55_02_05_00_07);
        left = 300;
        while (ntx < b + 3 && left > 0) begin tick(); left--; end
        checks++; if (ntx - b != 3) begin errors++; $display("FAIL rst_reach_byte2: got %0d expected 3", ntx - b); end
        rst = 1'b1;
        tick();
        outs = {tx_data, tx_int, reg_we, reg_re, reg_addr, reg_wdata, frame_err};
        checks++; if (outs !== 35'h0) begin errors++; $display("FAIL rst_midtx: got %h expected 0", outs); end
        rst = 1'b0;
        repeat (30) tick();
        checks++; if (ntx - b != 3) begin errors++; $display("FAIL rst_no_repeat: got %0d expected 3", ntx - b); end
        b = ntx;
        send_frame(40'h55_01_03_A5_A9);
        wait_tx(b + 4, 200, "rst_fresh");
        checks++; if (txword(b) !== 32'hAA00A5A5) begin errors++; $display("FAIL rst_fresh_resp: got %h expected AA00A5A5", txword(b)); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_garbage();
        test_timeout();
        test_back_to_back_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
